data_sram_bridge: RTL
=====================

Name: data_sram_bridge

Overview:
Memory-stage bridge between the pipelined core's combinational data port and a handshaked SRAM-like data bus (req / addr_ok / data_ok).
- Converts each M-stage load or store into one bus transaction.
- Holds the pipeline with stallM until the transaction completes.
- Returns load data to the writeback path.
- Sits directly downstream of the core's M-stage outputs (address from ALU, store data, byte write enables).

Parameters:
DATA_W, 32, data bus and register width
ADDR_W, 32, address width
ADDR_MAP, 1, 1 = map kseg0/kseg1 (0x8000_0000–0xBFFF_FFFF) to physical by clearing addr[31:29]; 0 = pass-through

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
memenM  in  1  M-stage instruction is a load or store
memwriteM  in  1  1 = store, 0 = load
sizeM  in  2  access size: 0 byte, 1 half, 2 word
addrM  in  ADDR_W  virtual byte address (ALU result)
writedataM  in  DATA_W  store data, already lane-replicated
wenM  in  4  store byte enables
ext_stallM  in  1  M stage held by another unit
readdataM  out  DATA_W  latched load word (raw, unaligned lanes)
stallM  out  1  hold F/D/E/M stages
data_req  out  1  bus request
data_wr  out  1  1 = write
data_size  out  2  equals sizeM
data_addr  out  ADDR_W  mapped address
data_wdata  out  DATA_W  equals writedataM
data_wstrb  out  4  wenM on store, 4'b0000 on load
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response / write done
data_rdata  in  DATA_W  read data, valid with data_data_ok

Behaviour:
- Reset (sync, active-high): state=IDLE; readdataM=0; data_req=0. stallM follows the state equations below, so it is memenM in IDLE.
- States: IDLE, WAIT, DONE.
- IDLE:
  - data_req = memenM; request fields driven combinationally from M inputs.
  - data_req && data_addr_ok → WAIT.
  - stallM = memenM.
- WAIT:
  - data_req=0; stallM=1.
  - data_data_ok → DONE, readdataM <= data_rdata (loads only; stores leave readdataM unchanged).
- DONE:
  - stallM=0; data_req=0.
  - ext_stallM=1 → stay DONE (no re-issue).
  - Else → IDLE (pipeline advances on this edge).
- Minimum occupancy: 3 cycles per access (IDLE accept, WAIT data_ok, DONE). stallM is high for 2 of them.
- data_data_ok in IDLE or DONE is ignored. data_addr_ok while data_req=0 is ignored.
- M inputs stay stable while stallM=1 (guaranteed by the core). The bridge does not re-latch them.
- Address mapping (ADDR_MAP=1): addr[31:30]==2'b10 → data_addr = {3'b000, addr[28:0]}; otherwise unchanged.
- One outstanding transaction maximum.
- Reset mid-WAIT: the bus is reset in the same cycle, so no data_ok drain is performed.
- memenM=0 in IDLE: all bus outputs inactive (req=0), stallM=0.

Optional Feature:
DBRIDGE_FLUSH_EN
- Defined:
  - Adds input flushM (1 bit) and state CANCEL.
  - flushM in IDLE suppresses data_req.
  - flushM in WAIT → CANCEL.
  - CANCEL: data_req=0, stallM=memenM; on data_data_ok, discard data (readdataM unchanged) → IDLE.
  - flushM in DONE → IDLE.
- Not defined: no flushM port, no CANCEL state; behaviour as above.

Test Plan:
- Load word: memenM=1, memwriteM=0, sizeM=2, addrM=0xBFC0_0010; addr_ok in cycle 0, data_ok with rdata=0x1234_5678 in cycle 2 → data_addr=0x1FC0_0010, data_wstrb=0, stallM high cycles 0–2, readdataM=0x1234_5678 in DONE (cycle 3).
- Store byte: memwriteM=1, sizeM=0, addrM=0x8000_0003, wenM=4'b1000, writedataM=0xAAAA_AAAA → data_wr=1, data_addr=0x0000_0003, data_wstrb=4'b1000; readdataM unchanged.
- Slow addr_ok (3 cycles low) then data_ok after 4 cycles → data_req held high exactly until acceptance, single transaction, stallM low only in DONE.
- ext_stallM=1 for 2 cycles in DONE → state stays DONE, data_req stays 0, no second request, readdataM stable.
- Back-to-back loads 0x10 then 0x14 → two distinct transactions. Second req asserted in the cycle after DONE.
- (DBRIDGE_FLUSH_EN) flushM in WAIT, then data_ok with rdata=0xDEAD_BEEF → readdataM keeps its prior value, state returns to IDLE. A new load's data_req is not asserted before that data_ok.

Source files
------------

// File: rtl/data_sram_bridge_if.sv
// Handshaked SRAM-like data bus (req / addr_ok / data_ok) between the M-stage bridge and memory.
interface data_sram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata, wstrb,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, wstrb,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// M-stage bridge: one bus transaction per load/store, pipeline held via stallM until done.
// Optional DBRIDGE_FLUSH_EN adds flushM and a CANCEL state that drains a flushed access.
module data_sram_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ADDR_MAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic              memwriteM,
  input  logic [1:0]        sizeM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic [3:0]        wenM,
  input  logic              ext_stallM,
`ifdef DBRIDGE_FLUSH_EN
  input  logic              flushM,
`endif
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  data_sram_bridge_if.master data
);

`ifdef DBRIDGE_FLUSH_EN
  typedef enum logic [1:0] {IDLE, WAIT, DONE, CANCEL} state_t;
  logic flush;
  assign flush = flushM;
`else
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  logic flush;
  assign flush = 1'b0;
`endif

  state_t            state;
  state_t            next_state;
  logic              capture;
  logic [ADDR_W-1:0] mapped_addr;

  // kseg0/kseg1 fold onto physical memory by clearing the top three address bits.
  always_comb begin
    mapped_addr = addrM;
    if (ADDR_MAP != 0 && addrM[ADDR_W-1 -: 2] == 2'b10)
      mapped_addr[ADDR_W-1 -: 3] = 3'b000;
  end

  assign data.wr    = memenM & memwriteM;
  assign data.size  = sizeM;
  assign data.addr  = mapped_addr;
  assign data.wdata = writedataM;
  assign data.wstrb = (memenM && memwriteM) ? wenM : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      readdataM <= '0;
    end else begin
      state <= next_state;
      if (capture)
        readdataM <= data.rdata;
    end
  end

  always_comb begin
    next_state = state;
    data.req   = 1'b0;
    stallM     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        data.req = memenM & ~flush & ~rst;
        stallM   = memenM;
        if (data.req && data.addr_ok)
          next_state = WAIT;
      end
      WAIT: begin
        stallM = 1'b1;
        // A flush racing the response simply discards it; otherwise drain later in CANCEL.
        if (flush) begin
`ifdef DBRIDGE_FLUSH_EN
          next_state = data.data_ok ? IDLE : CANCEL;
`endif
        end else if (data.data_ok) begin
          next_state = DONE;
          capture    = ~memwriteM;
        end
      end
      DONE: begin
        if (flush || !ext_stallM)
          next_state = IDLE;
      end
`ifdef DBRIDGE_FLUSH_EN
      CANCEL: begin
        stallM = memenM;
        if (data.data_ok)
          next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule
